// File: rtl/spart_rx_fifo.sv
// SPART receive channel: mid-bit sampling of a synchronised rxd with a programmable divisor,
// optional parity, and a show-ahead FIFO of {perr, ferr, data} entries.
module spart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 8,
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic [15:0]          divisor_i,
    input  logic                 rxd_i,
    input  logic                 rd_en_i,
    input  logic                 clr_ovr_i,
    output logic                 rda_o,
    output logic [DATA_BITS-1:0] rdata_o,
    output logic                 rd_perr_o,
    output logic                 rd_ferr_o,
    output logic [CNT_W-1:0]     rx_count_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    // state    | meaning
    // S_IDLE   | waiting for en & low rxd
    // S_START  | timing to mid start bit, rejects glitches
    // S_DATA   | shifting DATA_BITS samples, LSB first
    // S_PARITY | sampling the parity bit
    // S_STOP   | sampling the stop bit, pushes the frame
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int EW    = DATA_BITS + 2;

    state_t               state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [15:0]          div_q, div_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 perr_q, perr_d;
    logic                 rxd_s1_q, rxd_s2_q;
    logic [15:0]          div_eff;
    logic                 tick;
    logic                 push, push_ferr;
    logic                 odd_par;

    logic [EW-1:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 overrun_q;
    logic                 full, pop, wr_ok;
    logic [EW-1:0]        head;

    assign div_eff = (divisor_i < 16'd2) ? 16'd2 : divisor_i;
    assign tick    = (cnt_q == 16'd0);
    assign odd_par = (PARITY == 2);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rxd_s1_q <= 1'b1;
            rxd_s2_q <= 1'b1;
        end else begin
            rxd_s1_q <= rxd_i;
            rxd_s2_q <= rxd_s1_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= 16'd2;
            bit_q   <= '0;
            sh_q    <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            perr_q  <= perr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        perr_d    = perr_q;
        push      = 1'b0;
        push_ferr = 1'b0;
        if (state_q != S_IDLE && !tick) begin
            cnt_d = cnt_q - 16'd1;
        end
        case (state_q)
            S_IDLE: begin
                if (en_i && !rxd_s2_q) begin
                    state_d = S_START;
                    div_d   = div_eff;
                    cnt_d   = (div_eff >> 1) - 16'd1;
                    bit_d   = '0;
                    perr_d  = 1'b0;
                end
            end
            S_START: begin
                if (tick) begin
                    cnt_d   = div_q - 16'd1;
                    state_d = rxd_s2_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    cnt_d = div_q - 16'd1;
                    sh_d  = {rxd_s2_q, sh_q[DATA_BITS-1:1]};
                    if (bit_q == 4'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    cnt_d   = div_q - 16'd1;
                    perr_d  = ((^sh_q) ^ rxd_s2_q) != odd_par;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
                    push      = 1'b1;
                    push_ferr = ~rxd_s2_q;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign rda_o = (count_q != '0);
    assign pop   = rd_en_i & rda_o;
    // When full, a simultaneous pop frees the slot the write lands in.
    assign wr_ok = push & (~full | pop);

    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= {perr_q, push_ferr, sh_q};
        end
    end

    always_comb begin
        count_d = count_q;
        case ({wr_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            if (push && full && !pop) begin
                overrun_q <= 1'b1;
            end else if (clr_ovr_i) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign rdata_o    = rda_o ? head[DATA_BITS-1:0] : '0;
    assign rd_ferr_o  = rda_o & head[DATA_BITS];
    assign rd_perr_o  = rda_o & head[EW-1] & (PARITY != 0);
    assign rx_count_o = count_q;
    assign overrun_o  = overrun_q;
    assign busy_o     = (state_q != S_IDLE);

endmodule
